// File: rtl/rr_arbiter8_pkg.sv
// Shared arbiter types and constants: state encoding, full-width sizes, priority scan.
// Used combinationally by the arbiter; no timing or flow-control behaviour of its own.
// The scan helper finds the first set request at or after the priority pointer.
package arb_pkg;

    localparam int ARB_N    = 8;
    localparam int ARB_IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Scan ptr, ptr+1, ... with natural modulo-ARB_N wrap. Bits above the
    // real requester count are zero-padded by the caller, so a narrower
    // arbiter still wraps modulo its own N.
    function automatic logic [ARB_IDXW-1:0] first_from_ptr(
        input logic [ARB_N-1:0]    req,
        input logic [ARB_IDXW-1:0] ptr
    );
        logic [ARB_IDXW-1:0] win;
        logic [ARB_IDXW-1:0] idx;
        logic                found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < ARB_N; i++) begin
            idx = ptr + ARB_IDXW'(i);
            if (req[idx] && !found) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// Carries no state; timing is set by the arbiter.
// Flow control is request-level: requesters hold req until granted.
interface rr_arbiter8_if #(
    parameter int N    = 8,
    parameter int IDXW = 3
);
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; output is all zero when disabled.
// Purely combinational, zero latency.
// No flow control.
module onehot_dec #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic [IDXW-1:0] idx,
    input  logic            en,
    output logic [N-1:0]    dec
);
    always_comb begin
        dec = '0;
        if (en) begin
            dec[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: N requesters share one resource, one-hot grant via decoder.
// Latency: request sampled at one edge is granted at the next; one dead cycle between grants.
// Owner holds until done, req drop, or the MAX_HOLD limit (timeout pulse) revokes it.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter8_if.slave bus
);
    localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

    arb_state_t      state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] gnt_idx_q;
    logic            gnt_valid_q;
    logic            timeout_q;
    logic [HCW-1:0]  hold_cnt;

    logic [ARB_N-1:0] req_pad;
    logic [IDXW-1:0]  winner;
    logic             owner_req;
    logic             limit_hit;

    assign req_pad   = ARB_N'(bus.req);
    assign winner    = IDXW'(first_from_ptr(req_pad, ARB_IDXW'(ptr)));
    assign owner_req = bus.req[gnt_idx_q];
    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (|bus.req) begin
                        gnt_idx_q   <= winner;
                        gnt_valid_q <= 1'b1;
                        hold_cnt    <= HOLD_ONE;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // done/req-drop outrank the hold limit, so a coincident
                    // done never reports a timeout.
                    if (bus.done || !owner_req || limit_hit) begin
                        timeout_q   <= !(bus.done || !owner_req);
                        gnt_valid_q <= 1'b0;
                        ptr         <= gnt_idx_q + 1'b1;
                        hold_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        timeout_q <= 1'b0;
                        if (MAX_HOLD != 0 && hold_cnt != HOLD_LIM) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    gnt_valid_q <= 1'b0;
                    timeout_q   <= 1'b0;
                end
            endcase
        end
    end

    logic [N-1:0] gnt_dec;

    onehot_dec #(
        .N    (N),
        .IDXW (IDXW)
    ) u_dec (
        .idx (gnt_idx_q),
        .en  (gnt_valid_q),
        .dec (gnt_dec)
    );

    assign bus.gnt       = gnt_dec;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule
